fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 16, sets the instruction word width.
REQ-002 Parameter LDM_OP, default 5'b10100, is the LDM opcode, compared against instruction[WIDTH-1:WIDTH-5].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_addr  output  32  instruction memory word address; memory read is combinational.
REQ-006 imem_data  input  WIDTH  word at imem_addr, valid in the same cycle.
REQ-007 fetch_pc_enable  input  1  0 holds PC and the IF/ID register.
REQ-008 load_use  input  1  load-use stall; holds PC and the IF/ID register.
REQ-009 flush_fetch  input  1  IF/ID register loads NOP.
REQ-010 pc_sel  input  2  next-PC select: 00 sequential, 01 jump, 10 popped PC, 11 reserved (treated as 00).
REQ-011 branch_taken  input  1  qualifies pc_sel=01.
REQ-012 pc_jmp  input  32  jump target.
REQ-013 pc_mem  input  32  PC popped by RET/RTI.
REQ-014 interrupt  input  1  external interrupt request, level.
REQ-015 ack  input  1  decode acknowledges the interrupt request.
REQ-016 instruction  output  WIDTH  IF/ID instruction register.
REQ-017 pc_out  output  32  PC+1 of the word in instruction, used for call push.
REQ-018 imm_flag  output  1  instruction holds the LDM immediate word, not an opcode.
REQ-019 int_req  output  1  interrupt pending toward decode.
REQ-020 int_ret_pc  output  32  return PC saved at interrupt entry.

Function
REQ-021 FSM states: BOOT_HI, BOOT_LO, RUN, INT_HI, INT_LO.
REQ-022 BOOT_HI: imem_addr=0; latch imem_data as PC[31:16]; go to BOOT_LO.
REQ-023 BOOT_LO: imem_addr=1; load PC = {latched hi, imem_data}; go to RUN.
REQ-024 In BOOT and INT states, no fetch occurs and the IF/ID register loads NOP (16'h0000, imm_flag=0).
REQ-025 In RUN, imem_addr equals PC.
REQ-026 RUN next-state priority, highest first: redirect, flush, stall, interrupt, sequential.
REQ-027 Redirect occurs when (pc_sel=01 and branch_taken) or pc_sel=10.
- PC loads pc_jmp or pc_mem respectively.
- IF/ID loads NOP.
- Pending-immediate flag clears.
REQ-028 Flush: flush_fetch=1 without redirect loads NOP into IF/ID, advances PC by 1, and clears the pending-immediate flag.
REQ-029 Stall: load_use=1 or fetch_pc_enable=0 holds PC, IF/ID and the pending-immediate flag unchanged.
REQ-030 Interrupt entry occurs when interrupt=1, int_req=0 and no pending immediate.
- int_ret_pc <= PC and int_req <= 1.
- IF/ID loads NOP.
- FSM goes to INT_HI.
REQ-031 INT_HI: imem_addr=2; latch the high half.
REQ-032 INT_LO: imem_addr=3; PC = {hi, imem_data}; go to RUN.
REQ-033 int_req stays 1 until a cycle with ack=1, then clears on the next edge; while int_req=1, interrupt is ignored.
REQ-034 ack=1 coinciding with int_req being set has no effect until the following cycle.
REQ-035 Sequential fetch: instruction <= imem_data; pc_out <= PC+1; PC <= PC+1.
- PC arithmetic is 32-bit modulo; 32'hFFFFFFFF wraps to 0.
REQ-036 A fetched word whose opcode equals LDM_OP with imm_flag=0 sets the pending-immediate flag.
- The next fetched word is loaded with imm_flag=1 and is never decoded as LDM.
- The flag then clears.
REQ-037 Redirect or flush in BOOT/INT states is ignored.
REQ-038 Stall in BOOT/INT states is ignored; those states always advance.

Reset
REQ-039 rst=1 at an edge, in any state and including mid-INT or mid-BOOT, sets:
- FSM to BOOT_HI; PC to 0.
- instruction, pc_out, imm_flag, int_req, int_ret_pc, pending-immediate flag and latched hi all to 0.
REQ-040 rst dominates every other input in the same cycle.
REQ-041 Outputs hold their reset values until the first RUN fetch or interrupt entry.

Verification
REQ-042 Boot: imem[0]=16'h0000, imem[1]=16'h0020, release rst -> two NOP cycles, then imem_addr=32'h20 and the next instruction=imem[32'h20] with pc_out=32'h21.
REQ-043 Stall/redirect priority: load_use=1 with pc_sel=01, branch_taken=1, pc_jmp=32'h40 -> PC=32'h40 and instruction=NOP next cycle (redirect beats stall); load_use=1 alone -> PC and instruction unchanged for each stall cycle.
REQ-044 LDM: fetch {LDM_OP,11'h0} then 16'h1F00 -> second word shows imm_flag=1; a flush between the two words -> the following word has imm_flag=0.
REQ-045 Interrupt: PC=32'h50, interrupt=1, imem[2..3]=0000/0100 -> int_ret_pc=32'h50, int_req=1, two NOP cycles, fetch resumes at 32'h100; int_req clears the cycle after ack=1; interrupt held high is not re-taken before ack.
REQ-046 Interrupt deferred: interrupt asserted the cycle an LDM is fetched -> the immediate word is fetched first, and entry occurs on the next cycle.
REQ-047 Reset mid-INT_LO -> all outputs 0 and FSM restarts at BOOT_HI (imem_addr=0).

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit and its environment: instruction memory port,
// pipeline control inputs, interrupt handshake and the IF/ID register outputs.
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic [31:0]      imem_addr;
  logic [WIDTH-1:0] imem_data;
  logic             fetch_pc_enable;
  logic             load_use;
  logic             flush_fetch;
  logic [1:0]       pc_sel;
  logic             branch_taken;
  logic [31:0]      pc_jmp;
  logic [31:0]      pc_mem;
  logic             interrupt;
  logic             ack;
  logic [WIDTH-1:0] instruction;
  logic [31:0]      pc_out;
  logic             imm_flag;
  logic             int_req;
  logic [31:0]      int_ret_pc;

  modport master (
    output imem_addr, instruction, pc_out, imm_flag, int_req, int_ret_pc,
    input  imem_data, fetch_pc_enable, load_use, flush_fetch, pc_sel, branch_taken,
           pc_jmp, pc_mem, interrupt, ack
  );

  modport slave (
    input  imem_addr, instruction, pc_out, imm_flag, int_req, int_ret_pc,
    output imem_data, fetch_pc_enable, load_use, flush_fetch, pc_sel, branch_taken,
           pc_jmp, pc_mem, interrupt, ack
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: boots PC from imem[0..1], vectors interrupts through imem[2..3],
// and tags the word following an LDM as an immediate.
module fetch_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter logic [4:0]  LDM_OP = 5'b10100
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {StBootHi, StBootLo, StRun, StIntHi, StIntLo} state_e;

  state_e           st_q, st_d;
  logic [31:0]      pc_q, pc_d;
  logic [15:0]      hi_q, hi_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [31:0]      pc_out_q, pc_out_d;
  logic             imm_q, imm_d;
  logic             int_req_q, int_req_d;
  logic [31:0]      int_ret_q, int_ret_d;
  logic [31:0]      addr;

  logic [15:0] word;
  logic [4:0]  opcode;
  logic        redirect;
  logic        stall;

  assign word     = bus.imem_data[15:0];
  assign opcode   = bus.imem_data[WIDTH-1 -: 5];
  assign redirect = (bus.pc_sel == 2'b01 && bus.branch_taken) || bus.pc_sel == 2'b10;
  assign stall    = bus.load_use || !bus.fetch_pc_enable;

  always_comb begin
    st_d      = st_q;
    pc_d      = pc_q;
    hi_d      = hi_q;
    pend_d    = pend_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    imm_d     = imm_q;
    int_req_d = int_req_q;
    int_ret_d = int_ret_q;
    addr      = pc_q;

    // An ack seen while the request is already up clears it; entry needs int_req_q=0.
    if (int_req_q && bus.ack) int_req_d = 1'b0;

    unique case (st_q)
      StBootHi, StIntHi: begin
        addr    = (st_q == StBootHi) ? 32'd0 : 32'd2;
        hi_d    = word;
        instr_d = '0;
        imm_d   = 1'b0;
        st_d    = (st_q == StBootHi) ? StBootLo : StIntLo;
      end
      StBootLo, StIntLo: begin
        addr    = (st_q == StBootLo) ? 32'd1 : 32'd3;
        pc_d    = {hi_q, word};
        instr_d = '0;
        imm_d   = 1'b0;
        st_d    = StRun;
      end
      StRun: begin
        if (redirect) begin
          pc_d    = (bus.pc_sel == 2'b10) ? bus.pc_mem : bus.pc_jmp;
          instr_d = '0;
          imm_d   = 1'b0;
          pend_d  = 1'b0;
        end else if (bus.flush_fetch) begin
          pc_d    = pc_q + 32'd1;
          instr_d = '0;
          imm_d   = 1'b0;
          pend_d  = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (bus.interrupt && !int_req_q && !pend_q) begin
          int_ret_d = pc_q;
          int_req_d = 1'b1;
          instr_d   = '0;
          imm_d     = 1'b0;
          st_d      = StIntHi;
        end else begin
          instr_d  = bus.imem_data;
          pc_out_d = pc_q + 32'd1;
          pc_d     = pc_q + 32'd1;
          imm_d    = pend_q;
          // The immediate word itself is never decoded as an LDM.
          pend_d   = !pend_q && (opcode == LDM_OP);
        end
      end
      default: st_d = StBootHi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= StBootHi;
      pc_q      <= '0;
      hi_q      <= '0;
      pend_q    <= 1'b0;
      instr_q   <= '0;
      pc_out_q  <= '0;
      imm_q     <= 1'b0;
      int_req_q <= 1'b0;
      int_ret_q <= '0;
    end else begin
      st_q      <= st_d;
      pc_q      <= pc_d;
      hi_q      <= hi_d;
      pend_q    <= pend_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      imm_q     <= imm_d;
      int_req_q <= int_req_d;
      int_ret_q <= int_ret_d;
    end
  end

  assign bus.imem_addr   = addr;
  assign bus.instruction = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.imm_flag    = imm_q;
  assign bus.int_req     = int_req_q;
  assign bus.int_ret_pc  = int_ret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle model of the fetch rules checked every cycle, plus
// directed scenarios with literal expectations for boot, stall, LDM, interrupt and wrap.
module tb_fetch_unit;
  localparam logic [4:0] LDM = 5'b10100;

  logic clk = 1'b0;
  logic rst;
  logic fetch_pc_enable, load_use, flush_fetch, branch_taken, interrupt, ack;
  logic [1:0]  pc_sel;
  logic [31:0] pc_jmp, pc_mem;
  logic [15:0] mem [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.WIDTH(16)) bus ();

  assign bus.fetch_pc_enable = fetch_pc_enable;
  assign bus.load_use        = load_use;
  assign bus.flush_fetch     = flush_fetch;
  assign bus.pc_sel          = pc_sel;
  assign bus.branch_taken    = branch_taken;
  assign bus.pc_jmp          = pc_jmp;
  assign bus.pc_mem          = pc_mem;
  assign bus.interrupt       = interrupt;
  assign bus.ack             = ack;
  assign bus.imem_data       = mem[bus.imem_addr[11:0]];

  fetch_unit #(.WIDTH(16), .LDM_OP(LDM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: vector_left counts the remaining dead vector-fetch cycles (boot or interrupt).
  logic [31:0] m_pc, m_pc_out, m_ret, m_vec_base;
  logic [15:0] m_instr, m_vec_hi;
  logic        m_imm, m_req, m_expect_imm;
  bit          m_valid = 0;
  int          m_vec_left;

  function automatic logic [31:0] m_addr();
    if (m_vec_left == 2) return m_vec_base;
    if (m_vec_left == 1) return m_vec_base + 32'd1;
    return m_pc;
  endfunction

  task automatic model_step();
    logic [31:0] a;
    logic [15:0] w;
    logic        req_was;
    a = m_addr();
    w = mem[a[11:0]];
    if (rst) begin
      m_pc = 0; m_pc_out = 0; m_ret = 0; m_instr = 0; m_vec_hi = 0;
      m_imm = 0; m_req = 0; m_expect_imm = 0;
      m_vec_left = 2; m_vec_base = 0; m_valid = 1;
    end else begin
      req_was = m_req;
      if (m_vec_left != 0) begin
        if (m_vec_left == 2) m_vec_hi = w;
        else m_pc = {m_vec_hi, w};
        m_vec_left--;
        m_instr = 0; m_imm = 0;
      end else if ((pc_sel == 2'b01 && branch_taken) || pc_sel == 2'b10) begin
        m_pc = (pc_sel == 2'b10) ? pc_mem : pc_jmp;
        m_instr = 0; m_imm = 0; m_expect_imm = 0;
      end else if (flush_fetch) begin
        m_pc = m_pc + 1;
        m_instr = 0; m_imm = 0; m_expect_imm = 0;
      end else if (load_use || !fetch_pc_enable) begin
        m_pc = m_pc;
      end else if (interrupt && !req_was && !m_expect_imm) begin
        m_ret = m_pc; m_req = 1;
        m_instr = 0; m_imm = 0;
        m_vec_left = 2; m_vec_base = 2;
      end else begin
        m_instr = w;
        m_imm = m_expect_imm;
        m_pc_out = m_pc + 1;
        m_pc = m_pc + 1;
        m_expect_imm = !m_expect_imm && (w[15:11] == LDM);
      end
      if (req_was && ack) m_req = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("imem_addr", bus.imem_addr, m_addr());
      chk("instruction", {16'h0, bus.instruction}, {16'h0, m_instr});
      chk("pc_out", bus.pc_out, m_pc_out);
      chk("imm_flag", {31'h0, bus.imm_flag}, {31'h0, m_imm});
      chk("int_req", {31'h0, bus.int_req}, {31'h0, m_req});
      chk("int_ret_pc", bus.int_ret_pc, m_ret);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    fetch_pc_enable = 1; load_use = 0; flush_fetch = 0; branch_taken = 0;
    interrupt = 0; ack = 0; pc_sel = 2'b00; pc_jmp = 0; pc_mem = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'h5A00;
    mem[0] = 16'h0000; mem[1] = 16'h0020; mem[2] = 16'h0000; mem[3] = 16'h0100;
    mem[12'h042] = 16'hA000; mem[12'h043] = 16'h1F00;
    mem[12'h044] = 16'hA000; mem[12'h045] = 16'hA123;
    mem[12'h048] = 16'hA000;
    mem[12'h104] = 16'hA000; mem[12'h105] = 16'h1234;
    idle();
    rst = 1;
    repeat (2) cyc();
    chk("lit_rst_addr", bus.imem_addr, 32'h0);
    chk("lit_rst_instr", {16'h0, bus.instruction}, 32'h0);
    rst = 0;
    cyc(); chk("lit_boot_lo_addr", bus.imem_addr, 32'h1);
    cyc(); chk("lit_boot_run_addr", bus.imem_addr, 32'h20);
    chk("lit_boot_nop", {16'h0, bus.instruction}, 32'h0);
    cyc(); chk("lit_first_instr", {16'h0, bus.instruction}, 32'h5A20);
    chk("lit_first_pc_out", bus.pc_out, 32'h21);
    cyc(); cyc();
    // Stall holds PC and IF/ID
    load_use = 1;
    cyc(); cyc();
    chk("lit_stall_addr", bus.imem_addr, 32'h23);
    chk("lit_stall_instr", {16'h0, bus.instruction}, 32'h5A22);
    // Redirect beats stall
    pc_sel = 2'b01; branch_taken = 1; pc_jmp = 32'h40;
    cyc();
    chk("lit_redir_addr", bus.imem_addr, 32'h40);
    chk("lit_redir_nop", {16'h0, bus.instruction}, 32'h0);
    idle(); pc_sel = 2'b01; cyc();
    pc_sel = 2'b11; cyc();
    idle(); cyc();
    chk("lit_ldm_instr", {16'h0, bus.instruction}, 32'hA000);
    cyc();
    chk("lit_imm_instr", {16'h0, bus.instruction}, 32'h1F00);
    chk("lit_imm_flag", {31'h0, bus.imm_flag}, 32'h1);
    cyc(); cyc();
    chk("lit_imm_ldm_op", {31'h0, bus.imm_flag}, 32'h1);
    cyc();
    chk("lit_after_imm", {31'h0, bus.imm_flag}, 32'h0);
    cyc(); cyc();
    flush_fetch = 1; cyc();
    chk("lit_flush_addr", bus.imem_addr, 32'h4A);
    flush_fetch = 0; cyc();
    chk("lit_flush_clears_imm", {31'h0, bus.imm_flag}, 32'h0);
    chk("lit_flush_next", {16'h0, bus.instruction}, 32'h5A4A);
    // Interrupt entry at PC 0x50
    pc_sel = 2'b10; pc_mem = 32'h50; cyc();
    chk("lit_pop_addr", bus.imem_addr, 32'h50);
    pc_sel = 2'b00; interrupt = 1; cyc();
    chk("lit_int_req", {31'h0, bus.int_req}, 32'h1);
    chk("lit_int_ret", bus.int_ret_pc, 32'h50);
    chk("lit_int_hi_addr", bus.imem_addr, 32'h2);
    flush_fetch = 1; load_use = 1; pc_sel = 2'b10; pc_mem = 32'h77; cyc();
    chk("lit_int_lo_addr", bus.imem_addr, 32'h3);
    flush_fetch = 0; load_use = 0; pc_sel = 2'b00; cyc();
    chk("lit_int_resume", bus.imem_addr, 32'h100);
    cyc();
    chk("lit_int_fetch", {16'h0, bus.instruction}, 32'h5B00);
    chk("lit_no_retake", {31'h0, bus.int_req}, 32'h1);
    ack = 1; cyc();
    chk("lit_ack_clears", {31'h0, bus.int_req}, 32'h0);
    ack = 0; interrupt = 0; cyc();
    // Deferred entry behind an LDM immediate
    cyc(); cyc();
    interrupt = 1; cyc();
    chk("lit_defer_imm", {31'h0, bus.imm_flag}, 32'h1);
    chk("lit_defer_no_req", {31'h0, bus.int_req}, 32'h0);
    ack = 1; cyc();
    chk("lit_defer_ret", bus.int_ret_pc, 32'h106);
    ack = 0; cyc();
    chk("lit_early_ack_ignored", {31'h0, bus.int_req}, 32'h1);
    cyc();
    ack = 1; cyc();
    ack = 0; interrupt = 0; cyc();
    // Reset during INT_LO
    interrupt = 1; cyc();
    chk("lit_int2_addr", bus.imem_addr, 32'h2);
    interrupt = 0; cyc();
    chk("lit_int2_lo", bus.imem_addr, 32'h3);
    rst = 1; cyc();
    chk("lit_mid_rst_addr", bus.imem_addr, 32'h0);
    chk("lit_mid_rst_req", {31'h0, bus.int_req}, 32'h0);
    chk("lit_mid_rst_ret", bus.int_ret_pc, 32'h0);
    chk("lit_mid_rst_pc_out", bus.pc_out, 32'h0);
    rst = 0; cyc(); cyc();
    chk("lit_reboot_addr", bus.imem_addr, 32'h20);
    // PC wrap
    pc_sel = 2'b01; branch_taken = 1; pc_jmp = 32'hFFFF_FFFF; cyc();
    chk("lit_wrap_addr", bus.imem_addr, 32'hFFFF_FFFF);
    idle(); cyc();
    chk("lit_wrap_instr", {16'h0, bus.instruction}, 32'h55FF);
    chk("lit_wrap_pc_out", bus.pc_out, 32'h0);
    chk("lit_wrap_next", bus.imem_addr, 32'h0);
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
